charge_detect: RTL and testbench



---
 rtl/charge_pkg.sv | 57 +++++
 rtl/charge_detect_tone_period_meter.sv | 67 ++++++
 rtl/charge_detect.sv | 152 +++++++++++++++
 tb/tb_charge_detect.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/charge_pkg.sv
// Shared types and constants for the piezo charge-tune detector.
package charge_pkg;

  // Note codes reported on note_code. NONE means "no note window matched".
  typedef enum logic [2:0] {
    NONE = 3'd0,
    G6   = 3'd1,
    C7   = 3'd2,
    E7   = 3'd3,
    G7   = 3'd4
  } note_t;

  // Segment tracker states, visible as charge_detect.state_q.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_TRACK = 2'd2
  } seg_state_t;

  // Nominal square-wave periods in 50 MHz clocks.
  localparam logic [15:0] G6_PERIOD = 16'd31888;
  localparam logic [15:0] C7_PERIOD = 16'd23890;
  localparam logic [15:0] E7_PERIOD = 16'd18960;
  localparam logic [15:0] G7_PERIOD = 16'd15944;

  localparam int          DUR_W   = 26;
  localparam logic [25:0] MAX_DUR = 26'h3FF_FFFF;

  localparam int    TUNE_LEN = 6;
  localparam note_t TUNE [TUNE_LEN] = '{G6, C7, E7, G7, E7, G7};

  // Tune lookup with constant indices; out-of-range indices give NONE.
  function automatic note_t tune_note(input logic [2:0] idx);
    note_t n;
    case (idx)
      3'd0:    n = TUNE[0];
      3'd1:    n = TUNE[1];
      3'd2:    n = TUNE[2];
      3'd3:    n = TUNE[3];
      3'd4:    n = TUNE[4];
      3'd5:    n = TUNE[5];
      default: n = NONE;
    endcase
    return n;
  endfunction

  // True when |p - nom| <= tol, evaluated without signed arithmetic.
  function automatic logic in_window(input logic [15:0] p, input logic [15:0] nom,
                                     input logic [15:0] tol);
    logic [16:0] p_plus_tol;
    logic [16:0] nom_plus_tol;
    p_plus_tol   = {1'b0, p} + {1'b0, tol};
    nom_plus_tol = {1'b0, nom} + {1'b0, tol};
    return (p_plus_tol >= {1'b0, nom}) && ({1'b0, p} <= nom_plus_tol);
  endfunction

endpackage

// File: rtl/charge_detect_tone_period_meter.sv
// Synchronizes tone_in, detects rising edges, measures the period between
// rises and classifies it against the four note windows.
module tone_period_meter
  import charge_pkg::*;
#(
  parameter logic [15:0] TOL          = 16'd512,
  parameter logic [15:0] SILENCE_CLKS = 16'd40000,
  parameter logic [15:0] NOM_G6       = G6_PERIOD,
  parameter logic [15:0] NOM_C7       = C7_PERIOD,
  parameter logic [15:0] NOM_E7       = E7_PERIOD,
  parameter logic [15:0] NOM_G7       = G7_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic        rise,
  output logic [15:0] p,
  output note_t       c,
  output logic        silence
);

  logic        sync1;
  logic        sync2;
  logic        prev;
  logic [15:0] per_cnt;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // Period counter: reloads to 1 on a rise so rises N clocks apart read N.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= 16'd0;
    end else if (rise) begin
      per_cnt <= 16'd1;
    end else if (per_cnt != 16'hFFFF) begin
      per_cnt <= per_cnt + 16'd1;
    end
  end

  assign p = per_cnt;

  // Windows are disjoint as long as TOL stays below half the smallest gap.
  always_comb begin
    c = NONE;
    if (in_window(per_cnt, NOM_G6, TOL))      c = G6;
    else if (in_window(per_cnt, NOM_C7, TOL)) c = C7;
    else if (in_window(per_cnt, NOM_E7, TOL)) c = E7;
    else if (in_window(per_cnt, NOM_G7, TOL)) c = G7;
  end

  // A rise reloads per_cnt, so it always wins over the silence threshold.
  assign silence = (per_cnt == SILENCE_CLKS) && !rise;

endmodule

// File: rtl/charge_detect.sv
// Listens to the piezo square wave, reports note segments and pulses
// charge_det when the G6,C7,E7,G7,E7,G7 charge tune is heard.
//
// Handshake: note_vld is a one-cycle pulse with no back-pressure; note_code
// and note_dur are valid in that cycle and hold until the next note_vld.
// charge_det is a one-cycle pulse, one clock after the completing note_vld.
module charge_detect
  import charge_pkg::*;
#(
  parameter logic [15:0] TOL          = 16'd512,
  parameter logic [7:0]  MIN_PERIODS  = 8'd4,
  parameter logic [15:0] SILENCE_CLKS = 16'd40000,
  parameter logic [15:0] NOM_G6       = G6_PERIOD,
  parameter logic [15:0] NOM_C7       = C7_PERIOD,
  parameter logic [15:0] NOM_E7       = E7_PERIOD,
  parameter logic [15:0] NOM_G7       = G7_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic        note_vld,
  output note_t       note_code,
  output logic [25:0] note_dur,
  output logic        charge_det,
  output logic        busy
);

  logic        rise;
  logic [15:0] p;
  note_t       c;
  logic        silence;

  seg_state_t  state_q;
  seg_state_t  state_d;
  note_t       cur;
  logic [7:0]  cnt;
  logic [25:0] dur;
  logic [2:0]  seq_idx;

  logic        load_seg;
  logic        inc_seg;
  logic        close_seg;
  logic [26:0] dur_sum;

  tone_period_meter #(
    .TOL          (TOL),
    .SILENCE_CLKS (SILENCE_CLKS),
    .NOM_G6       (NOM_G6),
    .NOM_C7       (NOM_C7),
    .NOM_E7       (NOM_E7),
    .NOM_G7       (NOM_G7)
  ) u_meter (
    .clk     (clk),
    .rst     (rst),
    .tone_in (tone_in),
    .rise    (rise),
    .p       (p),
    .c       (c),
    .silence (silence)
  );

  // Segment FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Segment FSM next state: the first rise only arms, since no period exists yet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rise) state_d = S_ARM;
      S_ARM:   if (rise && c != NONE) state_d = S_TRACK;
               else if (silence)      state_d = S_IDLE;
      S_TRACK: if (rise && c == NONE) state_d = S_ARM;
               else if (silence)      state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Segment FSM outputs: start, extend or close the current segment.
  always_comb begin
    busy      = (state_q != S_IDLE);
    load_seg  = 1'b0;
    inc_seg   = 1'b0;
    close_seg = 1'b0;
    if (state_q == S_ARM) begin
      load_seg = rise && (c != NONE);
    end else if (state_q == S_TRACK) begin
      inc_seg   = rise && (c == cur);
      load_seg  = rise && (c != cur) && (c != NONE);
      close_seg = (rise && (c != cur)) || silence;
    end
  end

  assign dur_sum = {1'b0, dur} + {11'd0, p};

  // Segment accumulators: period count and summed duration, both saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= NONE;
      cnt <= 8'd0;
      dur <= 26'd0;
    end else if (load_seg) begin
      cur <= c;
      cnt <= 8'd1;
      dur <= {10'd0, p};
    end else if (inc_seg) begin
      if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      dur <= dur_sum[26] ? MAX_DUR : dur_sum[25:0];
    end
  end

  // Report a closed segment only if it lasted long enough to be a real note.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_vld  <= 1'b0;
      note_code <= NONE;
      note_dur  <= 26'd0;
    end else begin
      note_vld <= 1'b0;
      if (close_seg && cnt >= MIN_PERIODS) begin
        note_vld  <= 1'b1;
        note_code <= cur;
        note_dur  <= dur;
      end
    end
  end

  // Tune matcher: a mismatching G6 can itself start a new attempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_idx    <= 3'd0;
      charge_det <= 1'b0;
    end else begin
      charge_det <= 1'b0;
      if (note_vld) begin
        if (note_code == tune_note(seq_idx)) begin
          if (seq_idx == 3'(TUNE_LEN - 1)) begin
            seq_idx    <= 3'd0;
            charge_det <= 1'b1;
          end else begin
            seq_idx <= seq_idx + 3'd1;
          end
        end else begin
          seq_idx <= (note_code == G6) ? 3'd1 : 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_charge_detect.sv
// Directed bench for charge_detect. Nominal periods are scaled down by 128
// (tolerance and silence threshold scaled to match) to keep runs short.
module tb_charge_detect;
  import charge_pkg::*;

  localparam logic [15:0] T_G6  = 16'd249;
  localparam logic [15:0] T_C7  = 16'd187;
  localparam logic [15:0] T_E7  = 16'd148;
  localparam logic [15:0] T_G7  = 16'd125;
  localparam logic [15:0] T_TOL = 16'd4;
  localparam logic [15:0] T_SIL = 16'd300;
  localparam logic [7:0]  T_MIN = 8'd4;
  localparam int          ODD   = 55;
  localparam int          LONG  = 350;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tone_in = 1'b0;
  logic        note_vld;
  note_t       note_code;
  logic [25:0] note_dur;
  logic        charge_det;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int last_vld_cyc = -1;

  // {charge expected next cycle, note code, duration}
  logic [29:0] exp_q[$];
  logic        chk_chg = 1'b0;
  logic        exp_chg = 1'b0;

  charge_detect #(
    .TOL          (T_TOL),
    .MIN_PERIODS  (T_MIN),
    .SILENCE_CLKS (T_SIL),
    .NOM_G6       (T_G6),
    .NOM_C7       (T_C7),
    .NOM_E7       (T_E7),
    .NOM_G7       (T_G7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .note_vld   (note_vld),
    .note_code  (note_code),
    .note_dur   (note_dur),
    .charge_det (charge_det),
    .busy       (busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Monitor: pops expected notes on note_vld and checks the charge pulse.
  initial begin
    logic [29:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (chk_chg) begin
          checks++;
          if (charge_det !== exp_chg) begin
            errors++;
            $display("FAIL charge_det: got %0b expected %0b", charge_det, exp_chg);
          end
          chk_chg = 1'b0;
        end else if (charge_det) begin
          checks++;
          errors++;
          $display("FAIL charge_det_spurious: got 1 expected 0");
        end
        if (note_vld) begin
          last_vld_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL note_unexpected: got code %0d dur %0d expected none",
                     note_code, note_dur);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (note_code !== e[28:26]) begin
              errors++;
              $display("FAIL note_code: got %0d expected %0d", note_code, e[28:26]);
            end
            checks++;
            if (note_dur !== e[25:0]) begin
              errors++;
              $display("FAIL note_dur: got %0d expected %0d", note_dur, e[25:0]);
            end
            chk_chg = 1'b1;
            exp_chg = e[29];
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_note(input note_t code, input int dur, input bit chg);
    exp_q.push_back({chg, code, 26'(dur)});
  endtask

  // Rising edge now; the next pulse's rise comes exactly gap clocks later.
  task automatic pulse(input int gap);
    tone_in  = 1'b1;
    rise_cyc = cyc;
    repeat (gap / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (gap - gap / 2) @(negedge clk);
  endtask

  task automatic note_run(input logic [15:0] per, input int n, input int tail);
    repeat (n) pulse(int'(per));
    pulse(tail);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  // Directed stimulus
  initial begin
    note_t       tune_n [6];
    logic [15:0] tune_p [6];
    note_t       bad_n  [8];
    logic [15:0] bad_p  [8];
    tune_n = '{G6, C7, E7, G7, E7, G7};
    tune_p = '{T_G6, T_C7, T_E7, T_G7, T_E7, T_G7};
    bad_n  = '{G6, C7, G6, C7, E7, G7, E7, G7};
    bad_p  = '{T_G6, T_C7, T_G6, T_C7, T_E7, T_G7, T_E7, T_G7};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_note_vld", note_vld, 0);
    chk("rst_note_code", note_code, NONE);
    chk("rst_note_dur", note_dur, 0);
    chk("rst_charge_det", charge_det, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 9 G6 periods then silence; note lands SIL+3 clocks after the last drive
    expect_note(G6, 9 * 249, 1'b0);
    note_run(T_G6, 9, LONG);
    wait_drain("t1_drain");
    chk("t1_latency", last_vld_cyc - rise_cyc, int'(T_SIL) + 3);
    chk("t1_busy_idle", busy, 0);

    // Tolerance edge: inside the window is reported, one beyond is not
    expect_note(C7, 6 * 191, 1'b0);
    note_run(T_C7 + T_TOL, 6, LONG);
    wait_drain("t2a_drain");
    repeat (6) pulse(int'(T_C7 + T_TOL) + 1);
    chk("t2b_busy_armed", busy, 1);
    pulse(LONG);
    chk("t2b_busy_idle", busy, 0);

    // Full tune with odd periods at each boundary
    for (int i = 0; i < 6; i++) begin
      expect_note(tune_n[i], 8 * int'(tune_p[i]), i == 5);
      note_run(tune_p[i], 8, (i == 5) ? LONG : ODD);
    end
    wait_drain("t3_drain");

    // Short segment is dropped; busy falls exactly at the silence threshold
    repeat (3) pulse(int'(T_E7));
    tone_in  = 1'b1;
    rise_cyc = cyc;
    repeat (int'(T_SIL) + 2) @(negedge clk);
    chk("t4_busy_before_sil", busy, 1);
    @(negedge clk);
    chk("t4_busy_after_sil", busy, 0);
    tone_in = 1'b0;
    repeat (10) @(negedge clk);

    // Broken tune, then the matcher recovers from the stray G6
    for (int i = 0; i < 8; i++) begin
      expect_note(bad_n[i], 5 * int'(bad_p[i]), i == 7);
      note_run(bad_p[i], 5, (i == 7) ? LONG : ODD);
    end
    wait_drain("t5_drain");

    // Reset mid-segment discards it and clears the tune progress
    expect_note(G6, 5 * 249, 1'b0);
    note_run(T_G6, 5, ODD);
    expect_note(C7, 5 * 187, 1'b0);
    note_run(T_C7, 5, ODD);
    repeat (6) pulse(int'(T_G7));
    rst = 1'b1;
    @(negedge clk);
    chk("t6_note_vld", note_vld, 0);
    chk("t6_note_code", note_code, NONE);
    chk("t6_note_dur", note_dur, 0);
    chk("t6_charge_det", charge_det, 0);
    chk("t6_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    expect_note(E7, 5 * 148, 1'b0);
    note_run(T_E7, 5, ODD);
    expect_note(G7, 5 * 125, 1'b0);
    note_run(T_G7, 5, ODD);
    expect_note(E7, 5 * 148, 1'b0);
    note_run(T_E7, 5, ODD);
    expect_note(G7, 5 * 125, 1'b0);
    note_run(T_G7, 5, ODD);
    expect_note(G6, 5 * 249, 1'b0);
    note_run(T_G6, 5, LONG);
    wait_drain("t6_drain");

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
